// File: rtl/crypto_seq_ctrl_if.sv
// Core-side handshake bundle: latched key/text and start pulse out,
// ready/done/cipher back. master = sequencer, slave = crypto core.
interface crypto_seq_ctrl_if #(
  parameter int KEY_WIDTH    = 128,
  parameter int TEXT_WIDTH   = 128,
  parameter int CIPHER_WIDTH = 128
);
  logic [KEY_WIDTH-1:0]    core_key;
  logic [TEXT_WIDTH-1:0]   core_text;
  logic                    core_start;
  logic                    core_ready;
  logic                    core_done;
  logic [CIPHER_WIDTH-1:0] core_cipher;

  modport master (
    output core_key, core_text, core_start,
    input  core_ready, core_done, core_cipher
  );

  modport slave (
    input  core_key, core_text, core_start,
    output core_ready, core_done, core_cipher
  );
endinterface

// File: rtl/crypto_seq_ctrl.sv
// Crypto sequencer: latches key/text on go, runs the core num_runs
// times, drives a delayed scope trigger window and captures the result.
// Ports: crypto_clk/crypto_rst_n (async active-low); register side
// go/num_runs/trig_delay/key_in/text_in; core bus via crypto_seq_ctrl_if
// master; status cipher_out/cipher_valid/busy/trigger/run_count/
// timeout_err.
// Option: define CRYPTO_SEQ_TIMEOUT_EN for the RUN watchdog (ERR state).
module crypto_seq_ctrl #(
  parameter int TEXT_WIDTH     = 128,
  parameter int KEY_WIDTH      = 128,
  parameter int CIPHER_WIDTH   = 128,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    crypto_clk,
  input  logic                    crypto_rst_n,
  input  logic                    go,
  input  logic [CNT_WIDTH-1:0]    num_runs,
  input  logic [CNT_WIDTH-1:0]    trig_delay,
  input  logic [KEY_WIDTH-1:0]    key_in,
  input  logic [TEXT_WIDTH-1:0]   text_in,
  crypto_seq_ctrl_if.master       core,
  output logic [CIPHER_WIDTH-1:0] cipher_out,
  output logic                    cipher_valid,
  output logic                    busy,
  output logic                    trigger,
  output logic [CNT_WIDTH-1:0]    run_count,
  output logic                    timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_RDY, S_START,
    S_RUN, S_CAPTURE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [KEY_WIDTH-1:0]    key_q;
  logic [TEXT_WIDTH-1:0]   text_q;
  logic [CNT_WIDTH-1:0]    nruns_q;
  logic [CNT_WIDTH-1:0]    tdly_q;
  logic [CNT_WIDTH-1:0]    dly_q;
  logic [CNT_WIDTH-1:0]    run_cnt_q;
  logic [CIPHER_WIDTH-1:0] cipher_q;
  logic                    valid_q;
  logic                    trig_q;

  logic [CNT_WIDTH-1:0] run_cnt_inc;
  logic [CNT_WIDTH-1:0] eff_runs;
  logic                 last_run;
  logic                 trig_hit;
  logic                 done_acc;

  assign run_cnt_inc = run_cnt_q + 1'b1;
  assign eff_runs    = (nruns_q == '0)
                     ? {{(CNT_WIDTH-1){1'b0}}, 1'b1}
                     : nruns_q;
  assign last_run    = (run_cnt_inc == eff_runs);
  assign trig_hit    = (dly_q == tdly_q);
  // dly_q is 0 only in the first RUN cycle, where done is not trusted
  assign done_acc    = core.core_done && (dly_q != '0);

`ifdef CRYPTO_SEQ_TIMEOUT_EN
  localparam int WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q;
  logic           tmo_q;
  logic           wd_hit;
  assign wd_hit      = (wd_q == WdW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (go) state_d = S_LOAD;
      S_LOAD:     state_d = S_WAIT_RDY;
      S_WAIT_RDY: if (core.core_ready) state_d = S_START;
      S_START:    state_d = S_RUN;
      S_RUN: begin
        if (done_acc) state_d = S_CAPTURE;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
        else if (wd_hit) state_d = S_ERR;
`endif
      end
      S_CAPTURE:  state_d = last_run ? S_IDLE : S_WAIT_RDY;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge crypto_clk or negedge crypto_rst_n) begin
    if (!crypto_rst_n) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  always_ff @(posedge crypto_clk or negedge crypto_rst_n) begin
    if (!crypto_rst_n) begin
      key_q     <= '0;
      text_q    <= '0;
      nruns_q   <= '0;
      tdly_q    <= '0;
      dly_q     <= '0;
      run_cnt_q <= '0;
      cipher_q  <= '0;
      valid_q   <= 1'b0;
      trig_q    <= 1'b0;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
      wd_q      <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      if (state_q == S_LOAD) begin
        key_q     <= key_in;
        text_q    <= text_in;
        nruns_q   <= num_runs;
        tdly_q    <= trig_delay;
        run_cnt_q <= '0;
        valid_q   <= 1'b0;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
        tmo_q     <= 1'b0;
`endif
      end
      if (state_q == S_START) begin
        dly_q  <= '0;
        trig_q <= 1'b0;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
        wd_q   <= '0;
`endif
      end
      if (state_q == S_RUN) begin
        if (dly_q != '1) dly_q <= dly_q + 1'b1;
        // counter walks past the match, so remember it
        if (trig_hit) trig_q <= 1'b1;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
        wd_q <= wd_q + 1'b1;
        if (wd_hit && !done_acc) tmo_q <= 1'b1;
`endif
      end
      if (state_q == S_CAPTURE) begin
        cipher_q  <= core.core_cipher;
        run_cnt_q <= run_cnt_inc;
        if (last_run) valid_q <= 1'b1;
      end
`ifdef CRYPTO_SEQ_TIMEOUT_EN
      if (state_q == S_ERR) valid_q <= 1'b0;
`endif
    end
  end

  assign core.core_key   = key_q;
  assign core.core_text  = text_q;
  assign core.core_start = (state_q == S_START);

  assign cipher_out   = cipher_q;
  assign cipher_valid = valid_q;
  assign busy         = (state_q != S_IDLE);
  assign trigger      = (state_q == S_RUN) && (trig_q || trig_hit);
  assign run_count    = run_cnt_q;

endmodule
